// File: rtl/spi_regbank.sv
// Register bank behind the SPI register-access slave: config, sticky events,
// write counter, hw snapshot and ID, plus fast-command decode and status byte.
module spi_regbank #(
  parameter int          ADDR_W = 3,
  parameter int          REG_W  = 8,
  parameter int unsigned ID     = 'h5A
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [ADDR_W-1:0]    reg_addr,
  input  logic [REG_W-1:0]     reg_data_o,
  input  logic                 reg_data_o_vld,
  input  logic [5:0]           fastcmd,
  input  logic                 fastcmd_vld,
  output logic [REG_W-1:0]     reg_data_i,
  output logic [7:0]           status,
  output logic [4*REG_W-1:0]   cfg_o,
  input  logic [REG_W-1:0]     hw_i,
  input  logic [REG_W-1:0]     evt_i,
  output logic                 start_o,
  output logic                 irq_o
);

  localparam logic [REG_W-1:0] ID_EXT = REG_W'(ID);

  logic [REG_W-1:0]            hw_s1_q, hw_s2_q;
  logic [REG_W-1:0]            evt_s1_q, evt_s2_q, evt_s3_q;
  logic [3:0][REG_W-1:0]       cfg_q, cfg_d;
  logic [REG_W-1:0]            sticky_q, sticky_d;
  logic [REG_W-1:0]            wr_cnt_q, wr_cnt_d;
  logic [REG_W-1:0]            snap_q, snap_d;
  logic                        ro_err_q, ro_err_d;
  logic                        seen_q, seen_d;
  logic                        start_q, start_d;
  logic                        irq_q, irq_d;
  logic [REG_W-1:0]            rdata_q, rdata_d;
  logic [7:0]                  status_q, status_d;

  logic cmd_soft, cmd_clr, cmd_go, cmd_snap;
  logic wr_cfg, wr_w1c, wr_ro;
  logic [REG_W-1:0] evt_rise;

  assign cmd_soft = fastcmd_vld && (fastcmd == 6'h01);
  assign cmd_clr  = fastcmd_vld && (fastcmd == 6'h02);
  assign cmd_go   = fastcmd_vld && (fastcmd == 6'h03);
  assign cmd_snap = fastcmd_vld && (fastcmd == 6'h04);
  assign wr_cfg   = reg_data_o_vld && !reg_addr[2];
  assign wr_w1c   = reg_data_o_vld && (reg_addr == ADDR_W'(5));
  assign wr_ro    = reg_data_o_vld && reg_addr[2] && (reg_addr != ADDR_W'(5));
  assign evt_rise = evt_s2_q & ~evt_s3_q;

  always_comb begin
    cfg_d    = cfg_q;
    sticky_d = sticky_q;
    wr_cnt_d = wr_cnt_q;
    snap_d   = snap_q;
    ro_err_d = ro_err_q;
    seen_d   = seen_q;
    if (wr_cfg) cfg_d[reg_addr[1:0]] = reg_data_o;
    if (wr_w1c) sticky_d = sticky_q & ~reg_data_o;
    if (wr_cfg || wr_w1c) wr_cnt_d = wr_cnt_q + 1'b1;
    if (wr_ro) ro_err_d = 1'b1;
    if (cmd_go) seen_d = 1'b1;
    if (cmd_snap) snap_d = hw_s2_q;
    if (cmd_clr) begin
      sticky_d = '0;
      ro_err_d = 1'b0;
      seen_d   = 1'b0;
    end
    // Event edges beat both W1C and the clear command.
    sticky_d = sticky_d | evt_rise;
    // Soft reset beats everything, including a write in the same cycle.
    if (cmd_soft) begin
      cfg_d    = '0;
      sticky_d = '0;
      wr_cnt_d = '0;
      snap_d   = '0;
      ro_err_d = 1'b0;
      seen_d   = 1'b0;
    end
  end

  always_comb begin
    rdata_d = '0;
    case (reg_addr)
      ADDR_W'(0): rdata_d = cfg_q[0];
      ADDR_W'(1): rdata_d = cfg_q[1];
      ADDR_W'(2): rdata_d = cfg_q[2];
      ADDR_W'(3): rdata_d = cfg_q[3];
      ADDR_W'(4): rdata_d = snap_q;
      ADDR_W'(5): rdata_d = sticky_q;
      ADDR_W'(6): rdata_d = wr_cnt_q;
      default:    rdata_d = ID_EXT;
    endcase
  end

  assign irq_d    = |(sticky_q & cfg_q[3]);
  assign status_d = {irq_d, ro_err_q, seen_q, wr_cnt_q[4:0]};
  assign start_d  = cmd_go;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hw_s1_q  <= '0;
      hw_s2_q  <= '0;
      evt_s1_q <= '0;
      evt_s2_q <= '0;
      evt_s3_q <= '0;
      cfg_q    <= '0;
      sticky_q <= '0;
      wr_cnt_q <= '0;
      snap_q   <= '0;
      ro_err_q <= 1'b0;
      seen_q   <= 1'b0;
      start_q  <= 1'b0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
      status_q <= '0;
    end else begin
      hw_s1_q  <= hw_i;
      hw_s2_q  <= hw_s1_q;
      evt_s1_q <= evt_i;
      evt_s2_q <= evt_s1_q;
      evt_s3_q <= evt_s2_q;
      cfg_q    <= cfg_d;
      sticky_q <= sticky_d;
      wr_cnt_q <= wr_cnt_d;
      snap_q   <= snap_d;
      ro_err_q <= ro_err_d;
      seen_q   <= seen_d;
      start_q  <= start_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
    end
  end

  assign cfg_o      = cfg_q;
  assign reg_data_i = rdata_q;
  assign status     = status_q;
  assign start_o    = start_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_spi_regbank.sv
// Directed + randomized bench for spi_regbank against a register-map reference model.
module tb_spi_regbank;
  localparam int RW = 8;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic [2:0]      reg_addr = '0;
  logic [RW-1:0]   reg_data_o = '0;
  logic            reg_data_o_vld = 1'b0;
  logic [5:0]      fastcmd = '0;
  logic            fastcmd_vld = 1'b0;
  logic [RW-1:0]   reg_data_i;
  logic [7:0]      status;
  logic [4*RW-1:0] cfg_o;
  logic [RW-1:0]   hw_i = '0;
  logic [RW-1:0]   evt_i = '0;
  logic            start_o;
  logic            irq_o;

  spi_regbank #(.ADDR_W(3), .REG_W(RW), .ID('h5A)) dut (
    .clk(clk), .nrst(nrst), .reg_addr(reg_addr), .reg_data_o(reg_data_o),
    .reg_data_o_vld(reg_data_o_vld), .fastcmd(fastcmd), .fastcmd_vld(fastcmd_vld),
    .reg_data_i(reg_data_i), .status(status), .cfg_o(cfg_o), .hw_i(hw_i),
    .evt_i(evt_i), .start_o(start_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: register map contents plus the sampled input history.
  logic [RW-1:0] m_cfg [4];
  logic [RW-1:0] m_sticky, m_cnt, m_snap, m_rd;
  logic [RW-1:0] hw_hist [2];   // hw_i as seen 1 and 2 edges ago
  logic [RW-1:0] evt_hist [3];  // evt_i as seen 1, 2 and 3 edges ago
  logic [7:0]    m_st;
  logic          m_ro, m_seen, m_start, m_irq;

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_cfg[i] = '0;
    m_sticky = '0; m_cnt = '0; m_snap = '0; m_rd = '0; m_st = '0;
    m_ro = 0; m_seen = 0; m_start = 0; m_irq = 0;
    for (int i = 0; i < 2; i++) hw_hist[i] = '0;
    for (int i = 0; i < 3; i++) evt_hist[i] = '0;
  endtask

  function automatic logic [RW-1:0] m_read(input int a);
    if (a < 4) return m_cfg[a];
    if (a == 4) return m_snap;
    if (a == 5) return m_sticky;
    if (a == 6) return m_cnt;
    return RW'('h5A);
  endfunction

  task automatic compare();
    check("rdata", reg_data_i, m_rd);
    check("status", status, m_st);
    check("cfg_o", cfg_o, {m_cfg[3], m_cfg[2], m_cfg[1], m_cfg[0]});
    check("start_o", start_o, m_start);
    check("irq_o", irq_o, m_irq);
  endtask

  // One clock: drive at negedge, advance the model, check at the next negedge.
  task automatic cyc(input int a, input logic [RW-1:0] d, input bit v,
                     input logic [5:0] c, input bit cv);
    logic [RW-1:0] rise, n_rd;
    logic [7:0]    n_st;
    bit            n_irq;
    reg_addr = 3'(a); reg_data_o = d; reg_data_o_vld = v;
    fastcmd = c; fastcmd_vld = cv;
    n_rd  = m_read(a);
    n_irq = (m_sticky & m_cfg[3]) != 0;
    n_st  = {n_irq, m_ro, m_seen, m_cnt[4:0]};
    rise  = evt_hist[1] & ~evt_hist[2];
    if (cv && c == 6'h01) begin
      for (int i = 0; i < 4; i++) m_cfg[i] = '0;
      m_sticky = '0; m_cnt = '0; m_snap = '0; m_ro = 0; m_seen = 0;
    end else begin
      if (v && a < 4) begin m_cfg[a] = d; m_cnt = m_cnt + 1; end
      else if (v && a == 5) begin m_sticky = m_sticky & ~d; m_cnt = m_cnt + 1; end
      else if (v) m_ro = 1;
      if (cv && c == 6'h02) begin m_sticky = '0; m_ro = 0; m_seen = 0; end
      if (cv && c == 6'h03) m_seen = 1;
      if (cv && c == 6'h04) m_snap = hw_hist[1];
      m_sticky = m_sticky | rise;
    end
    hw_hist[1] = hw_hist[0]; hw_hist[0] = hw_i;
    evt_hist[2] = evt_hist[1]; evt_hist[1] = evt_hist[0]; evt_hist[0] = evt_i;
    m_rd = n_rd; m_st = n_st; m_irq = n_irq;
    m_start = cv && (c == 6'h03);
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int a);
    cyc(a, '0, 1'b0, 6'h00, 1'b0);
  endtask

  initial begin
    m_reset();
    #12;
    check("rst_rdata", reg_data_i, 0);
    check("rst_status", status, 0);
    check("rst_cfg", cfg_o, 0);
    check("rst_start", start_o, 0);
    check("rst_irq", irq_o, 0);
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      idle(i);
      check($sformatf("rd%0d", i), reg_data_i, (i == 7) ? 32'h5A : 32'h0);
    end

    cyc(2, 'hA5, 1, 6'h00, 0);
    check("cfg2_wr", cfg_o[23:16], 'hA5);
    idle(2);
    check("cfg2_rd", reg_data_i, 'hA5);
    check("cnt_1", status[4:0], 1);

    cyc(6, 'h33, 1, 6'h00, 0);
    idle(6);
    check("ro_err_set", status[6], 1);
    check("ro_cnt", reg_data_i, 1);
    cyc(6, '0, 0, 6'h02, 1);
    idle(6);
    check("ro_err_clr", status[6], 0);

    cyc(3, 'h01, 1, 6'h00, 0);
    evt_i = 'h01;
    for (int i = 0; i < 4; i++) idle(5);
    check("evt_irq", irq_o, 1);
    check("evt_st7", status[7], 1);
    evt_i = 'h00;
    for (int i = 0; i < 3; i++) idle(5);
    evt_i = 'h01;
    idle(5);
    idle(5);
    cyc(5, 'h01, 1, 6'h00, 0);
    idle(5);
    check("set_beats_w1c", reg_data_i[0], 1);
    evt_i = 'h00;

    hw_i = 'h3C;
    for (int i = 0; i < 3; i++) idle(4);
    cyc(4, '0, 0, 6'h04, 1);
    idle(4);
    check("snap_3c", reg_data_i, 'h3C);
    hw_i = 'hFF;
    for (int i = 0; i < 4; i++) idle(4);
    check("snap_hold", reg_data_i, 'h3C);

    cyc(0, '0, 0, 6'h01, 1);
    for (int i = 0; i < 255; i++) cyc(0, RW'(i + 1), 1, 6'h00, 0);
    idle(6);
    check("cnt_ff", reg_data_i, 'hFF);
    cyc(0, 'h11, 1, 6'h00, 0);
    idle(6);
    check("cnt_wrap", reg_data_i, 0);
    cyc(0, '0, 0, 6'h03, 1);
    check("start_hi", start_o, 1);
    idle(0);
    check("start_lo", start_o, 0);
    check("start_seen", status[5], 1);
    cyc(0, '0, 0, 6'h03, 1);
    cyc(0, '0, 0, 6'h03, 1);
    check("start_b2b", start_o, 1);
    idle(0);
    check("start_b2b_lo", start_o, 0);
    check("cfg_pre_soft", cfg_o[7:0], 'h11);
    cyc(0, 'h77, 1, 6'h01, 1);
    check("soft_cfg", cfg_o, 0);
    idle(0);
    check("soft_status", status, 0);

    // Async reset while a start pulse is on the wire.
    cyc(1, 'h55, 1, 6'h00, 0);
    reg_data_o_vld = 0; fastcmd = 6'h03; fastcmd_vld = 1;
    @(posedge clk);
    #1;
    check("pre_rst_start", start_o, 1);
    fastcmd_vld = 0;
    #2 nrst = 1'b0;
    #1;
    check("arst_start", start_o, 0);
    check("arst_cfg", cfg_o, 0);
    check("arst_status", status, 0);
    @(negedge clk);
    m_reset();
    nrst = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      int a;
      logic [5:0] c;
      if ($urandom_range(0, 7) == 0) hw_i = RW'($urandom);
      if ($urandom_range(0, 4) == 0) evt_i = RW'($urandom);
      a = $urandom_range(0, 7);
      c = 6'($urandom_range(0, 7));
      if (c == 6'h01 && $urandom_range(0, 3) != 0) c = 6'h00;
      cyc(a, RW'($urandom), $urandom_range(0, 2) == 0, c, $urandom_range(0, 5) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/spi_regbank.md
# spi_regbank

Register bank that sits directly downstream of the SPI register-access slave in the same clock domain. It decodes write strobes and fast commands from the slave, holds configuration, sticky event and counter registers, and returns read data and an 8-bit status byte to the slave. It is the only block that owns user-visible register state behind the SPI port.

## Interface
Parameters:
- ADDR_W, 3: register address width. Fixed at 3 (8 registers); other values are unsupported.
- REG_W, 8: register width in bits. Must be a multiple of 8 and at least 8.
- ID, 'h5A: constant returned at address 7, zero-extended to REG_W.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  system clock.
  - nrst  in  1  asynchronous active-low reset.
- From the SPI slave:
  - reg_addr  in  ADDR_W  current register address.
  - reg_data_o  in  REG_W  write data.
  - reg_data_o_vld  in  1  one-cycle write strobe.
  - fastcmd  in  6  fast command code.
  - fastcmd_vld  in  1  one-cycle fast command strobe.
- To the SPI slave:
  - reg_data_i  out  REG_W  registered read data for reg_addr.
  - status  out  8  registered status byte.
- To and from the rest of the design:
  - cfg_o  out  4*REG_W  cfg0..cfg3 concatenated, with cfg0 in the LSBs.
  - hw_i  in  REG_W  asynchronous hardware value, captured only on snapshot.
  - evt_i  in  REG_W  asynchronous event lines.
  - start_o  out  1  one-cycle start pulse.
  - irq_o  out  1  registered interrupt.

## Operation
Register map:
- 0..3: RW cfg0..cfg3. cfg3 is also the interrupt mask.
- 4: RO snapshot of hw_i.
- 5: W1C sticky event flags.
- 6: RO accepted-write counter.
- 7: RO ID.

Input synchronisation:
- hw_i and evt_i pass through 2-flop synchronisers.
- evt_i has a third flop for rising-edge detection.
- A rising edge on synchronised evt_i[k] sets sticky[k].

Writes (reg_data_o_vld=1):
- Address 0..3: cfg[reg_addr] <= reg_data_o; wr_cnt increments.
- Address 5: sticky <= sticky & ~reg_data_o; wr_cnt increments.
- Address 4, 6 or 7: no register change; ro_err sticky sets; wr_cnt unchanged.

wr_cnt:
- REG_W bits wide, wraps from all-ones to 0.

Fast commands, acted on only when fastcmd_vld=1:
- 6'h00: NOP.
- 6'h01: soft reset. cfg0..3, sticky, ro_err, wr_cnt and snapshot return to their reset values; synchronisers are not reset.
- 6'h02: clear sticky and ro_err.
- 6'h03: start_o=1 for exactly one cycle.
- 6'h04: snapshot <= synchronised hw_i.
- Any other code: ignored.

Status and interrupt:
- irq = |(sticky & cfg3).
- status = {irq, ro_err, start_seen, wr_cnt[4:0]}, registered.
- start_seen sets on the 6'h03 command and clears on 6'h02 or 6'h01.

Simultaneous events:
- Event set and W1C clear of the same bit in one cycle: set wins.
- Soft reset in the same cycle as a write: soft reset wins and the write is discarded.
- Clear (6'h02) in the same cycle as an event edge: the event bit stays set.

## Timing
- All outputs are registered.
- Reset values:
  - reg_data_i=0 and status=0.
  - cfg_o=0, start_o=0 and irq_o=0.
  - All internal registers are 0.
- Write latency: cfg_o reflects written data on the cycle after the strobe.
- Read latency:
  - reg_data_i reflects reg_addr and the register contents one cycle after either changes.
  - Read data shows the post-write value 2 cycles after a write strobe.
- start_o asserts one cycle after the 6'h03 strobe and lasts exactly one cycle.
- Back-to-back 6'h03 strobes on consecutive cycles give consecutive pulses.
- Event to sticky: 3 cycles from the evt_i edge (2 sync + 1 edge) to the sticky bit.
- Event to irq_o and status[7]: 1 cycle after the sticky bit.
- An evt_i level held high sets sticky once. It re-sets only after a low-to-high transition.
- Asynchronous reset mid-operation:
  - All state clears immediately.
  - A pending start_o pulse is dropped.

## Test plan
- Reset, then read addresses 0..7 -> all read 0 except address 7 = 'h5A; status=0, irq_o=0.
- Write 'hA5 to address 2 -> cfg_o[23:16]='hA5 next cycle; reading address 2 gives 'hA5; wr_cnt=1; status[4:0]=1.
- Write 'h33 to address 6 -> counter unchanged, status[6]=1; fastcmd 6'h02 -> status[6]=0.
- Set cfg3='h01 and pulse evt_i[0] -> sticky[0]=1 and irq_o=1 within 4 cycles of the edge. Then write 'h01 to address 5 while evt_i[0] rises again in the same cycle -> sticky[0] stays 1.
- Drive hw_i='h3C and wait 3 cycles, then issue fastcmd 6'h04 -> address 4 reads 'h3C. Change hw_i to 'hFF with no snapshot -> address 4 still reads 'h3C.
- Write 256 times to address 0 -> wr_cnt wraps to 0.
  - Then fastcmd 6'h03 -> single-cycle start_o and status[5]=1.
  - Then fastcmd 6'h01 -> cfg_o=0, status=0.
